// File: rtl/cnt_sweep_pkg.sv
// Shared types and sizing for the counter sweep controller.
package cnt_sweep_pkg;

  localparam int W_DEFAULT = 8;
  localparam int CYC_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DOWN,
    DONE
  } state_t;

endpackage

// File: rtl/cnt_sweep_ctrl.sv
// Drives an external up/down loadable counter through repeated lo->hi->lo sweeps.
// The counter only holds when loaded, so every non-counting state reloads its own value.
module cnt_sweep_ctrl
  import cnt_sweep_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     lo,
  input  logic [W-1:0]     hi,
  input  logic [CYC_W-1:0] cycles,
  input  logic [W-1:0]     count,
  output logic             cnt_load,
  output logic             cnt_u_d,
  output logic [W-1:0]     cnt_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [W-1:0]     ONE     = W'(1);
  localparam logic [CYC_W-1:0] REM_ONE = CYC_W'(1);

  state_t           state, next_state;
  logic [W-1:0]     lo_q, hi_q;
  logic [CYC_W-1:0] rem;

  logic start_ok, start_bad, turn_down, turn_up;

  always_comb begin
    next_state = state;
    cnt_load   = 1'b1;
    cnt_u_d    = 1'b1;
    cnt_data   = count;
    busy       = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    turn_down  = 1'b0;
    turn_up    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if ((lo < hi) && (cycles != '0)) begin
            start_ok   = 1'b1;
            next_state = LOAD;
          end else begin
            start_bad  = 1'b1;
          end
        end
      end
      LOAD: begin
        busy       = 1'b1;
        cnt_data   = lo_q;
        next_state = abort ? IDLE : UP;
      end
      UP: begin
        busy     = 1'b1;
        cnt_load = 1'b0;
        cnt_u_d  = 1'b1;
        // Turn one value early: the counter lands on hi_q on this same edge.
        if (abort) begin
          next_state = IDLE;
        end else if (count == hi_q - ONE) begin
          turn_down  = 1'b1;
          next_state = DOWN;
        end
      end
      DOWN: begin
        busy     = 1'b1;
        cnt_load = 1'b0;
        cnt_u_d  = 1'b0;
        if (abort) begin
          next_state = IDLE;
        end else if (count == lo_q + ONE) begin
          turn_up    = 1'b1;
          next_state = (rem > REM_ONE) ? UP : DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lo_q  <= '0;
      hi_q  <= '0;
      rem   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == DONE);
      err   <= start_bad;
      if (start_ok) begin
        lo_q <= lo;
        hi_q <= hi;
        rem  <= cycles;
      end else if (turn_up) begin
        rem  <= rem - REM_ONE;
      end
    end
  end

  // turn_down only documents the UP->DOWN edge; nothing else needs it.
  logic unused_turn_down;
  assign unused_turn_down = turn_down;

endmodule

// File: doc/cnt_sweep_ctrl.md
CNT_SWEEP_CTRL -- requirements
Module: cnt_sweep_ctrl

Interface
REQ-001 Parameter W SHALL default to 8: width of the counter value, bounds and load data.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all logic is sampled on posedge clk.
REQ-003 Port rst SHALL be an input, 1 bit, synchronous active-low reset.
REQ-004 Port start SHALL be an input, 1 bit, a request to begin a sweep job, sampled only in IDLE.
REQ-005 Port abort SHALL be an input, 1 bit, which terminates the job in progress.
REQ-006 Ports lo and hi SHALL be inputs, W bits each, giving the sweep bounds, captured at start.
REQ-007 Port cycles SHALL be an input, 4 bits, giving the number of full sweeps, captured at start.
REQ-008 Port count SHALL be an input, W bits, carrying the present value of the controlled counter.
REQ-009 Port cnt_load SHALL be an output, 1 bit, the load strobe to the counter.
REQ-010 Port cnt_u_d SHALL be an output, 1 bit, the direction to the counter (1 = up, 0 = down).
REQ-011 Port cnt_data SHALL be an output, W bits, the load value to the counter.
REQ-012 Port busy SHALL be an output, 1 bit, high while a job is active.
REQ-013 Port done SHALL be an output, 1 bit, a 1-cycle pulse when a job completes normally.
REQ-014 Port err SHALL be an output, 1 bit, a 1-cycle pulse when a start is rejected.

Function
REQ-015 States SHALL be IDLE, LOAD, UP, DOWN and DONE; the counter decrements whenever load=0 and u_d=0, so every non-counting state holds it by reload.
REQ-016 IDLE and DONE SHALL drive cnt_load=1 and cnt_data=count (hold); cnt_u_d=1 (don't-care).
REQ-017 IDLE: start with lo<hi and cycles!=0 SHALL capture lo_q, hi_q and rem=cycles, then go to LOAD.
REQ-018 IDLE: start with lo>=hi or cycles==0 SHALL pulse err the next cycle, capture nothing and stay in IDLE.
REQ-019 LOAD SHALL drive cnt_load=1 and cnt_data=lo_q for exactly 1 cycle, then go to UP.
REQ-020 UP SHALL drive cnt_load=0 and cnt_u_d=1; when count==hi_q-1 it SHALL go to DOWN, since the counter reaches hi_q on the same edge.
REQ-021 DOWN SHALL drive cnt_load=0 and cnt_u_d=0; when count==lo_q+1 it SHALL decrement rem and go to UP if rem>1, otherwise to DONE.
REQ-022 The resulting count trace SHALL be lo, lo+1 .. hi, hi-1 .. lo per sweep, 2*(hi-lo) cycles per sweep with no repeated or skipped values; hi==lo+1 is legal.
REQ-023 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-024 busy SHALL be 1 in LOAD, UP and DOWN, and 0 in IDLE and DONE.
REQ-025 start while busy SHALL be ignored, with no err.
REQ-026 abort in LOAD, UP or DOWN SHALL go to IDLE next cycle, with no done; the counter holds from that cycle on.
REQ-027 abort has priority over the UP/DOWN transitions; abort in IDLE or DONE SHALL be ignored.
REQ-028 start and abort together in IDLE SHALL be treated as start only.
REQ-029 cnt_* outputs SHALL be combinational from state, count and the captured registers; done and err SHALL be registered.
REQ-030 Compares SHALL be W-bit unsigned; hi_q-1 and lo_q+1 cannot wrap because lo_q<hi_q.

Reset
REQ-031 When rst=0 at posedge clk: state=IDLE, rem=0, lo_q=0, hi_q=0, done=0, err=0, busy=0.
REQ-032 Reset mid-job SHALL abandon the job with no done pulse; cnt_load=1 holds the counter from the first reset cycle.

Structure
REQ-033 Package cnt_sweep_pkg SHALL hold the state enum, the W default and the cycles width of 4.
REQ-034 The FSM and the rem/bound registers SHALL live in one module, with no sub-module.
REQ-035 The testbench SHALL pair the block with the team's 8-bit synchronous up/down loadable counter, with rst wired so that it is active-low.

Verification
REQ-036 Scenario: lo=3, hi=6, cycles=1, start -> count 3,4,5,6,5,4,3; done pulses once; busy high 7 cycles; count held at 3 afterward.
REQ-037 Scenario: lo=10, hi=11, cycles=3 -> count 10,11,10,11,10,11,10, then done.
REQ-038 Scenario: lo=8, hi=8, and separately cycles=0 -> err pulse, busy stays 0, count held.
REQ-039 Scenario: abort at count=5 mid-UP (lo=0, hi=9) -> IDLE next cycle, count frozen at 6, no done.
REQ-040 Scenario: start re-pulsed while busy, and rst=0 at count=4 -> the second start has no effect; reset forces IDLE with busy=0 and count held.
REQ-041 Scenario: lo=0, hi=255, cycles=1 -> full sweep with no wrap, 510 cycles, ends at 0.
